pci_arbiter_n: RTL and testbench

- Parametrised N-master PCI bus arbiter.
- Successor to the fixed three-master arbiter; the master count is now a parameter.
- Adds a grant-acquisition timeout, an idle-turnaround guarantee and status outputs.
- Sits between the PCI masters' REQ#/GNT# lines and the shared FRAME#/IRDY# bus signals; Mode selects fixed priority or round-robin.

---
 rtl/pci_arbiter_n.sv | 155 +++++++++++++++
 tb/tb_pci_arbiter_n.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pci_arbiter_n.sv
// N-master PCI bus arbiter: fixed-priority or round-robin winner selection,
// grant-acquisition timeout, one idle cycle between grants, registered outputs.
module pci_arbiter_n #(
  parameter int N_MASTERS   = 4,
  parameter int IDX_W       = 2,
  parameter int GNT_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Mode,
  input  logic [N_MASTERS-1:0] REQ_n,
  input  logic                 Frame,
  input  logic                 IRDY,
  output logic [N_MASTERS-1:0] GNT_n,
  output logic [IDX_W-1:0]     Grant_Idx,
  output logic                 Grant_Valid,
  output logic                 Timeout_Pulse
);

  typedef enum logic [1:0] {IDLE, GRANT, OWNED} state_t;

  state_t                 state_reg, state_next;
  logic [N_MASTERS-1:0]   gnt_n_reg, gnt_n_next;
  logic [IDX_W-1:0]       idx_reg, idx_next;
  logic [IDX_W-1:0]       last_reg, last_next;
  logic                   valid_reg, valid_next;
  logic                   tp_reg, tp_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;

  logic [N_MASTERS-1:0]   req;          // active-high requests
  logic [N_MASTERS-1:0]   above_last;   // indices after the round-robin pointer
  logic [N_MASTERS-1:0]   win_gnt_n;    // grant vector for the selected winner
  logic [N_MASTERS-1:0]   owner_oh;     // one-hot of the current grantee
  logic [IDX_W-1:0]       winner;
  logic [IDX_W-1:0]       low_any, low_hi;
  logic                   found_hi;
  logic                   any_req;
  logic                   bus_idle;
  logic                   owner_req;

  // Per-master decode: request polarity, round-robin mask, winner/owner one-hots
  for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_master
    assign req[gi]        = ~REQ_n[gi];
    assign above_last[gi] = (IDX_W'(gi) > last_reg);
    assign win_gnt_n[gi]  = (winner != IDX_W'(gi));
    assign owner_oh[gi]   = (idx_reg == IDX_W'(gi));
  end

  assign any_req   = |req;
  assign bus_idle  = Frame & IRDY;
  assign owner_req = |(req & owner_oh);

  // Winner: lowest requester overall, or (round-robin) lowest requester after
  // the pointer, wrapping to the lowest overall when none lies after it
  always_comb begin
    low_any  = '0;
    low_hi   = '0;
    found_hi = 1'b0;
    for (int i = N_MASTERS - 1; i >= 0; i--) begin
      if (req[i]) low_any = IDX_W'(i);
      if (req[i] && above_last[i]) begin
        low_hi   = IDX_W'(i);
        found_hi = 1'b1;
      end
    end
    winner = (Mode && found_hi) ? low_hi : low_any;
  end

  // Next-state and next-output logic for the IDLE/GRANT/OWNED sequence
  always_comb begin
    state_next = state_reg;
    gnt_n_next = gnt_n_reg;
    idx_next   = idx_reg;
    valid_next = valid_reg;
    tp_next    = 1'b0;
    last_next  = last_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        // A busy bus (including a foreign FRAME#) holds off arbitration
        if (any_req && bus_idle) begin
          state_next = GRANT;
          gnt_n_next = win_gnt_n;
          idx_next   = winner;
          valid_next = 1'b1;
          cnt_next   = '0;
        end
      end
      GRANT: begin
        if (!Frame) begin
          state_next = OWNED;
          last_next  = idx_reg;
          cnt_next   = '0;
        end else if (!owner_req) begin
          state_next = IDLE;
          gnt_n_next = '1;
          idx_next   = '0;
          valid_next = 1'b0;
        end else if (cnt_reg == CNT_W'(GNT_TIMEOUT - 1)) begin
          // Timed-out master moves to the back of the round-robin queue
          state_next = IDLE;
          gnt_n_next = '1;
          idx_next   = '0;
          valid_next = 1'b0;
          tp_next    = 1'b1;
          last_next  = idx_reg;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      OWNED: begin
        if (bus_idle) begin
          state_next = IDLE;
          gnt_n_next = '1;
          idx_next   = '0;
          valid_next = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
        gnt_n_next = '1;
        idx_next   = '0;
        valid_next = 1'b0;
      end
    endcase
  end

  // State and output registers; reset wins over any bus activity
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_reg <= IDLE;
      gnt_n_reg <= '1;
      idx_reg   <= '0;
      valid_reg <= 1'b0;
      tp_reg    <= 1'b0;
      last_reg  <= IDX_W'(N_MASTERS - 1);
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      gnt_n_reg <= gnt_n_next;
      idx_reg   <= idx_next;
      valid_reg <= valid_next;
      tp_reg    <= tp_next;
      last_reg  <= last_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign GNT_n         = gnt_n_reg;
  assign Grant_Idx     = idx_reg;
  assign Grant_Valid   = valid_reg;
  assign Timeout_Pulse = tp_reg;

endmodule

// File: tb/tb_pci_arbiter_n.sv
// Directed bench for pci_arbiter_n (4 masters, grant timeout of 4 cycles).
// Expected outputs are queued before each edge and compared just after it.
module tb_pci_arbiter_n;

  logic       Clk;
  logic       Rst;
  logic       Mode;
  logic [3:0] REQ_n;
  logic       Frame;
  logic       IRDY;
  logic [3:0] GNT_n;
  logic [1:0] Grant_Idx;
  logic       Grant_Valid;
  logic       Timeout_Pulse;

  pci_arbiter_n #(
    .N_MASTERS  (4),
    .IDX_W      (2),
    .GNT_TIMEOUT(4),
    .CNT_W      (3)
  ) dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .Mode         (Mode),
    .REQ_n        (REQ_n),
    .Frame        (Frame),
    .IRDY         (IRDY),
    .GNT_n        (GNT_n),
    .Grant_Idx    (Grant_Idx),
    .Grant_Valid  (Grant_Valid),
    .Timeout_Pulse(Timeout_Pulse)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    string      tag;
    int         sig;
    logic [7:0] exp;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  function automatic logic [7:0] observe(input int sig);
    case (sig)
      0:       return {4'b0, GNT_n};
      1:       return {6'b0, Grant_Idx};
      2:       return {7'b0, Grant_Valid};
      default: return {7'b0, Timeout_Pulse};
    endcase
  endfunction

  // Queue the expected outputs after the coming clock edge
  task automatic expect_out(input string tag, input logic [3:0] g, input logic [1:0] i,
                            input logic v, input logic t);
    sb.push_back('{{tag, ".gnt_n"}, 0, {4'b0, g}});
    sb.push_back('{{tag, ".idx"},   1, {6'b0, i}});
    sb.push_back('{{tag, ".valid"}, 2, {7'b0, v}});
    sb.push_back('{{tag, ".tpulse"}, 3, {7'b0, t}});
  endtask

  // Advance one edge, sample 1 time unit later, drain the scoreboard
  task automatic tick();
    exp_t       e;
    logic [7:0] o;
    @(posedge Clk);
    #1;
    $display("t=%0t GNT_n=%b idx=%0d valid=%b tpulse=%b", $time, GNT_n, Grant_Idx,
             Grant_Valid, Timeout_Pulse);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = observe(e.sig);
      total_cnt++;
      assert (o === e.exp) pass_cnt++;
      else $error("FAIL %s: observed %0h expected %0h", e.tag, o, e.exp);
    end
  endtask

  initial begin
    Rst   = 1'b1;
    Mode  = 1'b0;
    REQ_n = 4'b0000;
    Frame = 1'b0;
    IRDY  = 1'b1;

    // Reset held two cycles with requests pending and a busy bus
    expect_out("reset1", 4'b1111, 2'd0, 1'b0, 1'b0); tick();
    expect_out("reset2", 4'b1111, 2'd0, 1'b0, 1'b0); tick();
    Rst = 1'b0;
    expect_out("busy_idle1", 4'b1111, 2'd0, 1'b0, 1'b0); tick();
    expect_out("busy_idle2", 4'b1111, 2'd0, 1'b0, 1'b0); tick();
    Frame = 1'b1;
    expect_out("first_grant", 4'b1110, 2'd0, 1'b1, 1'b0); tick();
    REQ_n = 4'b1111;
    expect_out("first_withdraw", 4'b1111, 2'd0, 1'b0, 1'b0); tick();

    // Round-robin: all request, each owner holds FRAME# for two cycles
    Mode  = 1'b1;
    REQ_n = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      logic [3:0] g;
      logic [1:0] w;
      w = 2'(k % 4);
      g = 4'b1111;
      g[w] = 1'b0;
      Frame = 1'b1;
      expect_out($sformatf("rr%0d_grant", k), g, w, 1'b1, 1'b0); tick();
      Frame = 1'b0;
      expect_out($sformatf("rr%0d_own", k), g, w, 1'b1, 1'b0); tick();
      expect_out($sformatf("rr%0d_busy", k), g, w, 1'b1, 1'b0); tick();
      Frame = 1'b1;
      expect_out($sformatf("rr%0d_gap", k), 4'b1111, 2'd0, 1'b0, 1'b0); tick();
    end
    REQ_n = 4'b1111;
    expect_out("rr_done", 4'b1111, 2'd0, 1'b0, 1'b0); tick();

    // Fixed priority: masters 1 and 3 request, master 1 wins
    Mode  = 1'b0;
    REQ_n = 4'b0101;
    expect_out("fp_grant1", 4'b1101, 2'd1, 1'b1, 1'b0); tick();
    Frame = 1'b0;
    expect_out("fp_own1", 4'b1101, 2'd1, 1'b1, 1'b0); tick();
    Frame = 1'b1;
    REQ_n = 4'b0100;
    expect_out("fp_release1", 4'b1111, 2'd0, 1'b0, 1'b0); tick();
    expect_out("fp_grant0", 4'b1110, 2'd0, 1'b1, 1'b0); tick();
    REQ_n = 4'b1101;
    expect_out("fp_withdraw0", 4'b1111, 2'd0, 1'b0, 1'b0); tick();
    expect_out("fp_regrant1", 4'b1101, 2'd1, 1'b1, 1'b0); tick();

    // Withdrawal before FRAME#: release with no timeout pulse
    REQ_n = 4'b1111;
    expect_out("wd_release", 4'b1111, 2'd0, 1'b0, 1'b0); tick();
    expect_out("wd_idle", 4'b1111, 2'd0, 1'b0, 1'b0); tick();

    // Timeout: only master 2 requests and never drives FRAME#
    Mode  = 1'b1;
    REQ_n = 4'b1011;
    expect_out("to_grant", 4'b1011, 2'd2, 1'b1, 1'b0); tick();
    for (int c = 1; c < 4; c++) begin
      expect_out($sformatf("to_hold%0d", c), 4'b1011, 2'd2, 1'b1, 1'b0); tick();
    end
    expect_out("to_release", 4'b1111, 2'd0, 1'b0, 1'b1); tick();
    expect_out("to_regrant2", 4'b1011, 2'd2, 1'b1, 1'b0); tick();
    REQ_n = 4'b0011;
    for (int c = 1; c < 4; c++) begin
      expect_out($sformatf("to2_hold%0d", c), 4'b1011, 2'd2, 1'b1, 1'b0); tick();
    end
    expect_out("to2_release", 4'b1111, 2'd0, 1'b0, 1'b1); tick();
    expect_out("to2_grant3", 4'b0111, 2'd3, 1'b1, 1'b0); tick();

    // Mid-transaction reset while master 3 owns the bus
    Frame = 1'b0;
    expect_out("mr_own3", 4'b0111, 2'd3, 1'b1, 1'b0); tick();
    expect_out("mr_busy3", 4'b0111, 2'd3, 1'b1, 1'b0); tick();
    Rst   = 1'b1;
    REQ_n = 4'b0000;
    expect_out("mr_reset", 4'b1111, 2'd0, 1'b0, 1'b0); tick();
    Rst = 1'b0;
    expect_out("mr_frame_busy", 4'b1111, 2'd0, 1'b0, 1'b0); tick();
    Frame = 1'b1;
    IRDY  = 1'b0;
    expect_out("mr_irdy_busy", 4'b1111, 2'd0, 1'b0, 1'b0); tick();
    IRDY = 1'b1;
    expect_out("mr_grant0", 4'b1110, 2'd0, 1'b1, 1'b0); tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
